// File: rtl/adapter_pkg.sv
// Shared constants and length normalisation for the bus width adapters.
package adapter_pkg;

  localparam int unsigned BUS_WIDTH  = 32;
  localparam int unsigned DATA_WIDTH = 128;
  localparam int unsigned BEATS      = DATA_WIDTH / BUS_WIDTH;
  localparam int unsigned LEN_WIDTH  = 16;
  localparam int unsigned CNT_WIDTH  = $clog2(BEATS) + 1;

  // Map a requested beat count onto 1..beats: zero or oversize means a full word.
  function automatic logic [LEN_WIDTH-1:0] normalise_length(
    input logic [LEN_WIDTH-1:0] len,
    input int unsigned          beats
  );
    if (len == '0 || len > LEN_WIDTH'(beats)) begin
      return LEN_WIDTH'(beats);
    end
    return len;
  endfunction

endpackage

// File: rtl/adapter_to_bus.sv
// Width-down adapter: serialises one wide word into up to BEATS bus beats,
// highest valid word first, each beat tagged with its countdown length.
module adapter_to_bus
  import adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = adapter_pkg::DATA_WIDTH,
  parameter int unsigned BUS_WIDTH  = adapter_pkg::BUS_WIDTH
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  in_enq__ENA,
  input  logic [DATA_WIDTH-1:0] in_enq_v,
  input  logic [LEN_WIDTH-1:0]  in_enq_length,
  output logic                  in_enq__RDY,
  output logic                  out_enq__ENA,
  output logic [BUS_WIDTH-1:0]  out_enq_v,
  output logic [LEN_WIDTH-1:0]  out_enq_length,
  input  logic                  out_enq__RDY
);

  localparam int unsigned NBEATS = DATA_WIDTH / BUS_WIDTH;
  localparam int unsigned CNT_W  = $clog2(NBEATS) + 1;
  localparam int unsigned SEL_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic [DATA_WIDTH-1:0] buffer_q, buffer_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;

  logic                  busy;
  logic                  accept;
  logic                  beat_xfer;
  logic [CNT_W-1:0]      word_idx;
  logic [SEL_W-1:0]      sel;
  logic [LEN_WIDTH-1:0]  norm_len;

  assign busy     = (remaining_q != '0);
  assign word_idx = remaining_q - CNT_W'(1);
  assign sel      = word_idx[SEL_W-1:0];
  assign norm_len = normalise_length(in_enq_length, NBEATS);

  // Handshakes; taking a new word on the final beat's transfer avoids a bubble.
  always_comb begin
    in_enq__RDY = !busy || ((remaining_q == CNT_W'(1)) && out_enq__RDY);
    accept      = in_enq__ENA && in_enq__RDY;
    beat_xfer   = busy && out_enq__RDY;
  end

  // Beat output driven purely from state, zero when idle.
  always_comb begin
    out_enq__ENA   = busy;
    out_enq_v      = '0;
    out_enq_length = LEN_WIDTH'(remaining_q);
    if (busy) begin
      out_enq_v = buffer_q[sel*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  // Next-state: a new word overrides the last-beat decrement in the same cycle.
  always_comb begin
    buffer_d    = buffer_q;
    remaining_d = remaining_q;
    if (beat_xfer) begin
      remaining_d = remaining_q - CNT_W'(1);
    end
    if (accept) begin
      buffer_d    = in_enq_v;
      remaining_d = norm_len[CNT_W-1:0];
    end
  end

  // State registers, cleared asynchronously so a pending word is dropped on reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      buffer_q    <= '0;
      remaining_q <= '0;
    end else begin
      buffer_q    <= buffer_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_adapter_to_bus.sv
// Scoreboard bench for adapter_to_bus: accepted words expand into expected
// beat queues; a negedge monitor compares every beat and reassembles words.
module tb_adapter_to_bus;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         in_ena = 1'b0;
  logic [127:0] in_v = '0;
  logic [15:0]  in_len = '0;
  logic         in_rdy;
  logic         out_ena;
  logic [31:0]  out_v;
  logic [15:0]  out_len;
  logic         out_rdy = 1'b1;
  logic         rand_rdy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] v;
    int unsigned len;
  } beat_t;

  beat_t        q[$];
  logic [127:0] wq[$];
  logic [127:0] acc = '0;

  adapter_to_bus #(.DATA_WIDTH(128), .BUS_WIDTH(32)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .in_enq__ENA    (in_ena),
    .in_enq_v       (in_v),
    .in_enq_length  (in_len),
    .in_enq__RDY    (in_rdy),
    .out_enq__ENA   (out_ena),
    .out_enq_v      (out_v),
    .out_enq_length (out_len),
    .out_enq__RDY   (out_rdy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word of L beats becomes beats word[L-1]..word[0] tagged L..1.
  function automatic int unsigned beats_of(input logic [15:0] l);
    if (l == 0 || l > 4) return 4;
    return l;
  endfunction

  function automatic logic [127:0] low_words(input logic [127:0] w, input int unsigned n);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 32 * n; i++) m[i] = 1'b1;
    return w & m;
  endfunction

  // Monitor: inputs are stable between the negedge and the next posedge,
  // so handshakes observed here are the ones that complete on that posedge.
  always @(negedge CLK) begin
    if (!nRST) begin
      chk("rst_out_ena", out_ena, 0);
      chk("rst_out_len", out_len, 0);
      chk("rst_out_v", out_v, 0);
      chk("rst_in_rdy", in_rdy, 1);
      q.delete();
      wq.delete();
      acc = '0;
    end else begin
      chk("out_ena", out_ena, q.size() != 0);
      chk("in_rdy", in_rdy, (q.size() == 0) || (q.size() == 1 && out_rdy));
      if (q.size() != 0) begin
        chk("beat_v", out_v, q[0].v);
        chk("beat_len", out_len, q[0].len);
        if (out_rdy) begin
          beat_t b;
          b = q.pop_front();
          acc = (acc << 32) | 128'(b.v);
          if (b.len == 1) begin
            if (wq.size() != 0) chk("reassembled", acc, wq.pop_front());
            acc = '0;
          end
        end
      end else begin
        chk("idle_v", out_v, 0);
        chk("idle_len", out_len, 0);
      end
      if (in_ena && in_rdy) begin
        int unsigned l;
        l = beats_of(in_len);
        for (int k = l; k >= 1; k--) begin
          beat_t nb;
          nb.v   = 32'(in_v >> (32 * (k - 1)));
          nb.len = k;
          q.push_back(nb);
        end
        wq.push_back(low_words(in_v, l));
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
  end

  // Present a word and hold it until the monitor's negedge shows it is taken.
  task automatic send(input logic [127:0] w, input logic [15:0] l);
    int n;
    n = 0;
    @(posedge CLK); #1;
    in_ena = 1'b1;
    in_v   = w;
    in_len = l;
    forever begin
      @(negedge CLK);
      if (in_rdy) break;
      n++;
      if (n > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got in_rdy=0 expected 1 within 100 cycles");
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      in_ena = 1'b0;
      in_v   = {$urandom, $urandom, $urandom, $urandom};
      in_len = 16'($urandom);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge CLK);
    @(negedge CLK);
    chk("drain_empty", q.size(), 0);
  endtask

  localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] W2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  initial begin
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    idle(2);

    // Full word, partial word, and out-of-range lengths
    send(W1, 16'd4); idle(6);
    send(W1, 16'd2); idle(4);
    send(W1, 16'd0); idle(6);
    send(W1, 16'd9); idle(6);
    send(W2, 16'hF004); idle(6);
    send(W2, 16'd4); idle(6);

    // Back-to-back: len4 then len1 with no gap
    send(W2, 16'd4);
    send(W1, 16'd1);
    idle(6);

    // Stall on the len3 beat for three cycles
    send(W1, 16'd4);
    idle(2);
    out_rdy = 1'b0;
    repeat (3) @(posedge CLK);
    #1 out_rdy = 1'b1;
    idle(5);

    // Reset while the third beat is pending
    send(W1, 16'd4);
    idle(1);
    @(posedge CLK); #1;
    @(posedge CLK); #3;
    nRST = 1'b0;
    #1;
    chk("async_rst_ena", out_ena, 0);
    chk("async_rst_len", out_len, 0);
    chk("async_rst_in_rdy", in_rdy, 1);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    idle(3);
    send(W2, 16'd1); idle(4);
    drain();

    // Randomised words under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, 16'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(1);
    @(posedge CLK); #2;
    rand_rdy = 1'b0;
    out_rdy = 1'b1;
    drain();
    chk("words_done", wq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
